// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel writer.
// Holds the writer FSM state type, the RGB332 palette used by the
// escape-count colour map, and the default frame geometry.
package mandel_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_WRITE,
    S_ACK,
    S_RELEASE,
    S_FRAME_DONE
  } writer_state_t;

  // RGB332 palette, ordered from "inside the set" to "escaped fastest"
  localparam logic [7:0] ColorInside = 8'h00;
  localparam logic [7:0] ColorRed    = 8'hE0;
  localparam logic [7:0] ColorOrange = 8'hF0;
  localparam logic [7:0] ColorYellow = 8'hFC;
  localparam logic [7:0] ColorGreen  = 8'h1C;
  localparam logic [7:0] ColorCyan   = 8'h1F;
  localparam logic [7:0] ColorBlue   = 8'h03;

  localparam int unsigned DefHPixels = 640;
  localparam int unsigned DefVPixels = 480;

endpackage

// File: rtl/mandel_pixel_writer_if.sv
// Bus bundle between the Mandelbrot iterator, the pixel writer and the
// VGA frame buffer.
//   master : pixel-writer side (drives handshake and memory write port)
//   slave  : environment side (iterator + frame buffer)
interface mandel_pixel_writer_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              iter_done;
  logic              iter_all_done;
  logic [31:0]       iterations;
  logic [31:0]       max_iterations;
  logic              iter_handshake;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              mem_ready;

  modport master (
    input  iter_done, iter_all_done, iterations, max_iterations, mem_ready,
    output iter_handshake, mem_addr, mem_data, mem_we
  );

  modport slave (
    output iter_done, iter_all_done, iterations, max_iterations, mem_ready,
    input  iter_handshake, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/iter_color_map.sv
// Combinational escape-count to RGB332 colour map.
//   iterations     : escape count of the finished pixel
//   max_iterations : iteration limit used by the iterator
//   color          : RGB332 colour, first matching threshold wins
module iter_color_map
  import mandel_pkg::*;
(
  input  logic [31:0] iterations,
  input  logic [31:0] max_iterations,
  output logic [7:0]  color
);

  always_comb begin
    color = ColorBlue;
    if (iterations >= max_iterations) begin
      color = ColorInside;
    end else if (iterations >= (max_iterations >> 3)) begin
      color = ColorRed;
    end else if (iterations >= (max_iterations >> 4)) begin
      color = ColorOrange;
    end else if (iterations >= (max_iterations >> 5)) begin
      color = ColorYellow;
    end else if (iterations >= (max_iterations >> 6)) begin
      color = ColorGreen;
    end else if (iterations >= (max_iterations >> 7)) begin
      color = ColorCyan;
    end
  end

endmodule

// File: rtl/mandel_pixel_writer.sv
// Mandelbrot pixel writer: accepts finished pixels from the iterator, maps
// the escape count to RGB332, writes it to the frame buffer at the next
// raster address and handshakes back. Counts cycles until frame completion.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : iterator handshake + frame-buffer write port (master)
//   frame_done  : set once the iterator reports the range exhausted
//   cycle_count : cycles from reset release to frame completion, saturating
module mandel_pixel_writer
  import mandel_pkg::*;
#(
  parameter int unsigned H_PIXELS = DefHPixels,
  parameter int unsigned V_PIXELS = DefVPixels,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  mandel_pixel_writer_if.master  bus,
  output logic                   frame_done,
  output logic [31:0]            cycle_count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  writer_state_t     state_q;
  logic              mem_we_q;
  logic              handshake_q;
  logic              frame_done_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [7:0]        color_q;
  logic [31:0]       cycle_cnt_q;
  logic [7:0]        map_color;

  iter_color_map u_color_map (
    .iterations     (bus.iterations),
    .max_iterations (bus.max_iterations),
    .color          (map_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      mem_we_q     <= 1'b0;
      handshake_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_cnt_q    <= '0;
      color_q      <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      handshake_q <= 1'b0;
      if (state_q != S_FRAME_DONE && cycle_cnt_q != 32'hFFFF_FFFF) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      unique case (state_q)
        S_WAIT: begin
          // A pending pixel wins over end-of-range so nothing is dropped
          if (bus.iter_done) begin
            color_q  <= map_color;
            mem_we_q <= 1'b1;
            state_q  <= S_WRITE;
          end else if (bus.iter_all_done) begin
            frame_done_q <= 1'b1;
            state_q      <= S_FRAME_DONE;
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            mem_we_q    <= 1'b0;
            handshake_q <= 1'b1;
            state_q     <= S_ACK;
          end
        end
        S_ACK: begin
          pix_cnt_q <= (pix_cnt_q == LastAddr) ? '0 : pix_cnt_q + 1'b1;
          state_q   <= S_RELEASE;
        end
        S_RELEASE: begin
          // Iterator still shows the old done; wait for it to drop
          if (!bus.iter_done) begin
            state_q <= S_WAIT;
          end
        end
        S_FRAME_DONE: begin
          state_q <= S_FRAME_DONE;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = pix_cnt_q;
  assign bus.mem_data       = color_q;
  assign bus.iter_handshake = handshake_q;
  assign frame_done         = frame_done_q;
  assign cycle_count        = cycle_cnt_q;

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Self-checking bench for mandel_pixel_writer. A reduced 16x8 frame keeps the
// full-frame run short; the raster wrap and last-address logic are the same.
module tb_mandel_pixel_writer;

  localparam int unsigned HP = 16;
  localparam int unsigned VP = 8;
  localparam int unsigned NP = HP * VP;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  mandel_pixel_writer_if #(.ADDR_W(19)) bus ();

  mandel_pixel_writer #(
    .H_PIXELS (HP),
    .V_PIXELS (VP),
    .ADDR_W   (19)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .frame_done  (frame_done),
    .cycle_count (cycle_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;

  // Independent tally of non-reset cycles up to frame completion
  int tally = 0;
  logic tally_en = 1'b0;
  always @(posedge clk) if (!rst && tally_en) tally <= tally + 1;

  typedef struct {
    logic [31:0] it;
    logic [31:0] mx;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({name, "_hs"}, {31'd0, bus.iter_handshake}, 32'd0);
  endtask

  // One pixel transaction; called and returning at a negedge, DUT in S_WAIT.
  // stall: edges that see mem_ready low in S_WRITE.
  // hold : extra cycles iter_done stays high after the handshake.
  task automatic pixel(input logic [31:0] it, input logic [31:0] mx, input logic [7:0] data,
                       input int stall, input int hold);
    bus.iterations     = it;
    bus.max_iterations = mx;
    bus.mem_ready      = (stall == 0);
    bus.iter_done      = 1'b1;
    @(negedge clk);
    chk("we", {31'd0, bus.mem_we}, 32'd1);
    chk("addr", 32'(bus.mem_addr), exp_addr);
    chk("data", {24'd0, bus.mem_data}, {24'd0, data});
    chk("hs_early", {31'd0, bus.iter_handshake}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_we", {31'd0, bus.mem_we}, 32'd1);
      chk("stall_addr", 32'(bus.mem_addr), exp_addr);
      chk("stall_data", {24'd0, bus.mem_data}, {24'd0, data});
      chk("stall_hs", {31'd0, bus.iter_handshake}, 32'd0);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("hs", {31'd0, bus.iter_handshake}, 32'd1);
    chk("hs_we", {31'd0, bus.mem_we}, 32'd0);
    if (hold == 0) bus.iter_done = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk_idle("release");
      if (i == hold - 1) bus.iter_done = 1'b0;
    end
    @(negedge clk);
    exp_addr = (exp_addr + 1) % NP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iter_done = 1'b0;
    bus.iter_all_done = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tally = 0;
    tally_en = 1'b1;
    exp_addr = 0;
  endtask

  initial begin
    // boundary-heavy colour table: thresholds for max=1024 are 128/64/32/16/8
    vecs[0]  = '{32'd200, 32'd1024, 8'hE0};
    vecs[1]  = '{32'd70, 32'd1024, 8'hF0};
    vecs[2]  = '{32'd40, 32'd1024, 8'hFC};
    vecs[3]  = '{32'd20, 32'd1024, 8'h1C};
    vecs[4]  = '{32'd10, 32'd1024, 8'h1F};
    vecs[5]  = '{32'd3, 32'd1024, 8'h03};
    vecs[6]  = '{32'd128, 32'd1024, 8'hE0};
    vecs[7]  = '{32'd127, 32'd1024, 8'hF0};
    vecs[8]  = '{32'd1023, 32'd1024, 8'hE0};
    vecs[9]  = '{32'd5, 32'd0, 8'h00};
    vecs[10] = '{32'd0, 32'd0, 8'h00};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00};

    bus.iterations = '0;
    bus.max_iterations = '0;
    rst = 1'b1;
    bus.iter_done = 1'b0;
    bus.iter_all_done = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_hs", {31'd0, bus.iter_handshake}, 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_data", {24'd0, bus.mem_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    do_reset();

    // escape count at the limit -> inside colour at address 0
    pixel(32'd1000, 32'd1000, 8'h00, 0, 0);

    for (int v = 0; v < 12; v++) pixel(vecs[v].it, vecs[v].mx, vecs[v].data, 0, 0);

    // memory back-pressure, then iterator slow to drop done
    pixel(32'd70, 32'd1024, 8'hF0, 5, 0);
    pixel(32'd20, 32'd1024, 8'h1C, 0, 3);

    // reset during a write: the pixel is abandoned
    bus.iterations = 32'd200;
    bus.max_iterations = 32'd1024;
    bus.mem_ready = 1'b0;
    bus.iter_done = 1'b1;
    @(negedge clk);
    chk("midrst_we_before", {31'd0, bus.mem_we}, 32'd1);
    chk("midrst_data_before", {24'd0, bus.mem_data}, 32'hE0);
    rst = 1'b1;
    bus.iter_done = 1'b0;
    @(negedge clk);
    chk("midrst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("midrst_hs", {31'd0, bus.iter_handshake}, 32'd0);
    chk("midrst_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_data", {24'd0, bus.mem_data}, 32'd0);
    chk("midrst_cycles", cycle_count, 32'd0);
    rst = 1'b0;
    exp_addr = 0;
    pixel(32'd10, 32'd1024, 8'h1F, 0, 0);

    // full frame, wrap, then end of range arriving alongside a pixel
    do_reset();
    for (int p = 0; p < NP; p++) begin
      if (p == NP - 1) chk("last_addr", 32'(bus.mem_addr), NP - 1);
      pixel(32'd3, 32'd1024, 8'h03, 0, 0);
    end
    bus.iter_all_done = 1'b1;
    pixel(32'd40, 32'd1024, 8'hFC, 0, 0);
    chk("wrap_addr", 32'(bus.mem_addr), 32'd1);
    @(negedge clk);
    tally_en = 1'b0;
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("cycle_count", cycle_count, tally);
    bus.iter_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fd_hold", {31'd0, frame_done}, 32'd1);
      chk("fd_frozen", cycle_count, tally);
      chk_idle("fd_idle");
    end
    bus.iter_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
